// File: rtl/wb_dram_responder_model.sv
// Wishbone-classic stand-in for the DRAM wrapper: word array, fixed ack latency and an
// emulated calibration-done flag, so the self-test FSM can run without MIG/DRAM.
module wb_dram_responder_model #(
  parameter int unsigned WORD_SIZE   = 256,
  parameter int unsigned DEPTH_LOG2  = 6,
  parameter int unsigned ADDR_LSB    = 7,
  parameter int unsigned LATENCY     = 4,
  parameter int unsigned INIT_CYCLES = 1000
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  output logic                 initialized,
  input  logic                 cyc_i,
  input  logic                 stb_i,
  input  logic                 we_i,
  input  logic [31:0]          addr_i,
  input  logic [WORD_SIZE-1:0] data_i,
  output logic [WORD_SIZE-1:0] data_o,
  output logic                 ack_o
);

  localparam int unsigned Depth    = 2 ** DEPTH_LOG2;
  localparam int unsigned InitW    = (INIT_CYCLES < 2) ? 1 : $clog2(INIT_CYCLES);
  localparam int unsigned InitLast = (INIT_CYCLES == 0) ? 0 : INIT_CYCLES - 1;
  localparam int unsigned LatW     = (LATENCY < 2) ? 1 : $clog2(LATENCY);

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  state_e                  state_q, state_d;
  logic [LatW-1:0]         lat_q, lat_d;
  logic                    we_q, we_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [WORD_SIZE-1:0]    wdata_q, wdata_d;
  logic [WORD_SIZE-1:0]    rdata_q, rdata_d;
  logic [InitW-1:0]        init_cnt_q, init_cnt_d;
  logic                    init_q, init_d;
  logic                    mem_we;
  logic [DEPTH_LOG2-1:0]   req_idx;
  logic                    unused_addr;

  logic [WORD_SIZE-1:0] mem [Depth];

  // Only the index field of the address is decoded; the rest aliases.
  assign req_idx     = addr_i[ADDR_LSB +: DEPTH_LOG2];
  assign unused_addr = ^addr_i;

  assign initialized = init_q | (INIT_CYCLES == 0);
  assign ack_o       = (state_q == StAck);
  assign data_o      = rdata_q;

  always_comb begin
    init_d     = init_q;
    init_cnt_d = init_cnt_q;
    if (!init_q) begin
      if (init_cnt_q == InitW'(InitLast)) begin
        init_d = 1'b1;
      end else begin
        init_cnt_d = init_cnt_q + InitW'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    case (state_q)
      StIdle: begin
        if (cyc_i && stb_i && initialized) begin
          we_d    = we_i;
          idx_d   = req_idx;
          wdata_d = data_i;
          lat_d   = LatW'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_d = StAck;
            if (!we_i) begin
              rdata_d = mem[req_idx];
            end
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (!cyc_i) begin
          state_d = StIdle;
        end else begin
          lat_d = lat_q - LatW'(1);
          // Leaving WAIT as the count reaches zero puts ack exactly LATENCY cycles after accept.
          if (lat_q == LatW'(1)) begin
            state_d = StAck;
            if (!we_q) begin
              rdata_d = mem[idx_q];
            end
          end
        end
      end
      StAck: begin
        state_d = StIdle;
        mem_we  = we_q;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q    <= StIdle;
      lat_q      <= '0;
      we_q       <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      init_cnt_q <= '0;
      init_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      we_q       <= we_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      init_cnt_q <= init_cnt_d;
      init_q     <= init_d;
    end
  end

  // Array is deliberately not reset.
  always_ff @(posedge sys_clk) begin
    if (!rst && mem_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

endmodule
